// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner: row-multiplexed scan, column synchroniser, per-scan
// debounce FSM and a 4-digit entry shift register feeding the display.
module keypad_entry #(
    parameter int SCAN_BITS      = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col,
    input  logic        clear,
    output logic [3:0]  row,
    output logic [15:0] num,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [1:0]  fsm_state
);

    // key_valid is a one-cycle strobe with no backpressure; key_code holds the
    // last accepted code until the next accept, num updates on the same edge.

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int         LOW_BITS = SCAN_BITS - 2;
    localparam logic [3:0] DB       = 4'(DEBOUNCE_SCANS);

    logic [SCAN_BITS-1:0] scan_cnt;
    logic [1:0]           row_idx;
    logic                 row_end;
    logic                 scan_done;
    logic [3:0]           col_meta;
    logic [3:0]           col_sync;
    logic [15:0]          snapshot;
    logic [15:0]          snap_full;
    logic [4:0]           snap_ones;
    logic                 snap_single;
    logic                 snap_none;
    logic [3:0]           snap_idx;
    logic [3:0]           snap_code;
    state_t               state;
    logic [3:0]           cand;
    logic [3:0]           db_cnt;
    logic [3:0]           cnt_inc;
    logic                 at_limit;
    logic                 accept;

    function automatic logic [4:0] count_ones(input logic [15:0] v);
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc + 5'(v[i]);
        end
        return acc;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] decode_key(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign row_idx   = scan_cnt[SCAN_BITS-1 -: 2];
    assign row_end   = &scan_cnt[LOW_BITS-1:0];
    assign scan_done = row_end && (row_idx == 2'd3);

    // Scan counter, row drive and column synchroniser run regardless of keys.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            row      <= 4'b1110;
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            row      <= ~(4'b0001 << row_idx);
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            snapshot <= '0;
        end else if (row_end) begin
            snapshot[{row_idx, 2'b00} +: 4] <= ~col_sync;
        end
    end

    // The row-3 bits land in snapshot on the same edge the FSM reacts, so
    // merge them in combinationally to judge the scan that just finished.
    always_comb begin
        snap_full = snapshot;
        if (row_idx == 2'd3) begin
            snap_full[15:12] = ~col_sync;
        end
    end

    assign snap_ones   = count_ones(snap_full);
    assign snap_single = (snap_ones == 5'd1);
    assign snap_none   = (snap_ones == 5'd0);
    assign snap_idx    = lowest_set(snap_full);
    assign snap_code   = decode_key(snap_idx);

    assign cnt_inc  = db_cnt + 4'd1;
    assign at_limit = (cnt_inc >= DB);

    always_comb begin
        accept = 1'b0;
        if (scan_done && snap_single) begin
            if (state == IDLE) begin
                accept = (DB == 4'd1);
            end else if (state == PRESS_WAIT) begin
                accept = (snap_idx == cand) && at_limit;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            db_cnt    <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            num       <= '0;
        end else begin
            key_valid <= 1'b0;
            if (accept) begin
                key_valid <= 1'b1;
                key_code  <= snap_code;
            end
            if (clear) begin
                num <= '0;
            end else if (accept) begin
                num <= {num[11:0], snap_code};
            end

            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (snap_single) begin
                            cand   <= snap_idx;
                            db_cnt <= 4'd1;
                            state  <= (DB == 4'd1) ? HELD : PRESS_WAIT;
                        end
                    end
                    PRESS_WAIT: begin
                        if (snap_single) begin
                            if (snap_idx == cand) begin
                                db_cnt <= cnt_inc;
                                if (at_limit) begin
                                    state <= HELD;
                                end
                            end else begin
                                cand   <= snap_idx;
                                db_cnt <= 4'd1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        // Rollover chords keep us here; only a clean release re-arms.
                        if (snap_none) begin
                            db_cnt <= 4'd1;
                            state  <= (DB == 4'd1) ? IDLE : RELEASE_WAIT;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (snap_none) begin
                            db_cnt <= cnt_inc;
                            if (at_limit) begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model on the row/col wires, a scan-level
// behavioural model checked every cycle, and directed press sequences.
module tb_keypad_entry;

    localparam int SB = 4;
    localparam int D  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] num;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [1:0]  fsm_state;
    logic [15:0] keys = 16'h0000;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int p0;

    // Model state: n is the scan counter value in the current cycle.
    int          n = 0;
    logic [3:0]  exp_row = 4'b1110;
    logic [3:0]  exp_code = 4'h0;
    logic [15:0] exp_num = 16'h0000;
    logic        exp_valid = 1'b0;
    bit          armed = 1'b1;
    int          run_idx = 0;
    int          run_len = 0;
    int          none_len = 0;
    int          m_cnt;
    int          m_idx;

    logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] lit_rows [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    always #5 clock = ~clock;

    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
            end
        end
    end

    keypad_entry #(
        .SCAN_BITS(SB),
        .DEBOUNCE_SCANS(D)
    ) dut (
        .clock(clock),
        .reset(reset),
        .col(col),
        .clear(clear),
        .row(row),
        .num(num),
        .key_code(key_code),
        .key_valid(key_valid),
        .fsm_state(fsm_state)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare, then advance the model by one clock using the stable inputs.
    always @(negedge clock) begin
        check("row", row, exp_row);
        check("key_valid", key_valid, exp_valid);
        check("key_code", key_code, exp_code);
        check("num", num, exp_num);
        if (key_valid === 1'b1) pulses++;
        if (reset) begin
            n = 0; exp_row = 4'b1110; exp_code = 4'h0; exp_num = 16'h0;
            exp_valid = 1'b0; armed = 1'b1; run_len = 0; none_len = 0;
        end else begin
            exp_row = ~(4'b0001 << ((n % 16) / 4));
            exp_valid = 1'b0;
            if (n % 16 == 15) begin
                m_cnt = $countones(keys);
                m_idx = 0;
                for (int i = 15; i >= 0; i--) if (keys[i]) m_idx = i;
                if (armed) begin
                    if (m_cnt == 1) begin
                        if (run_len > 0 && m_idx == run_idx) run_len++;
                        else begin run_idx = m_idx; run_len = 1; end
                        if (run_len == D) begin
                            armed = 1'b0; none_len = 0; run_len = 0;
                            exp_valid = 1'b1;
                            exp_code = code_tab[m_idx];
                            exp_num = {exp_num[11:0], code_tab[m_idx]};
                        end
                    end else begin
                        run_len = 0;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        none_len++;
                        if (none_len == D) begin armed = 1'b1; run_len = 0; end
                    end else begin
                        none_len = 0;
                    end
                end
            end
            if (clear) exp_num = 16'h0;
            n++;
        end
    end

    task automatic next_scan();
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (n % 16 == 0) return;
        end
        tests++; fails++;
        $display("FAIL scan_align timeout at %0t", $time);
    endtask

    task automatic hold(input logic [15:0] m, input int k);
        next_scan();
        keys = m;
        repeat (k - 1) next_scan();
    endtask

    task automatic press(input int idx);
        hold(16'h0001 << idx, D);
        hold(16'h0000, D);
    endtask

    task automatic settle();
        next_scan();
        @(posedge clock); #1;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (n % 16 == ph) return;
        end
        tests++; fails++;
        $display("FAIL phase_wait timeout at %0t", $time);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        wait_phase(1);
        for (int i = 0; i < 4; i++) begin
            check("row_seq", row, lit_rows[i]);
            repeat (4) @(posedge clock);
            #1;
        end
        repeat (200) @(posedge clock);
        #1;
        check("idle_pulses", 16'(pulses), 16'd0);
        check("idle_num", num, 16'h0000);

        p0 = pulses;
        press(6); settle();
        check("k6_pulses", 16'(pulses - p0), 16'd1);
        check("k6_code", key_code, 4'h6);
        check("k6_num", num, 16'h0006);
        press(6); settle();
        check("k66_num", num, 16'h0066);

        p0 = pulses;
        press(0); press(1); press(2); press(3); press(7); settle();
        check("seq_pulses", 16'(pulses - p0), 16'd5);
        check("seq_num", num, 16'h23AB);

        p0 = pulses;
        hold(16'h0020, 1); hold(16'h0000, 1); hold(16'h0020, 1); hold(16'h0000, 1);
        settle();
        check("chatter_pulses", 16'(pulses - p0), 16'd0);
        hold(16'h0020, 2); hold(16'h0000, 2); settle();
        check("clean_pulses", 16'(pulses - p0), 16'd1);
        check("clean_code", key_code, 4'h5);
        check("clean_num", num, 16'h3AB5);

        p0 = pulses;
        hold(16'h8001, 3); settle();
        check("multi_pulses", 16'(pulses - p0), 16'd0);
        hold(16'h0001, 2); hold(16'h0000, 2); settle();
        check("rollover_pulses", 16'(pulses - p0), 16'd1);
        check("rollover_code", key_code, 4'h1);
        check("rollover_num", num, 16'hAB51);

        p0 = pulses;
        hold(16'h0200, 3); settle();
        check("pre_reset_pulses", 16'(pulses - p0), 16'd1);
        check("pre_reset_num", num, 16'hB518);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_row", row, 4'b1110);
        check("rst_num", num, 16'h0000);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        p0 = pulses;
        repeat (3) next_scan();
        settle();
        check("post_reset_pulses", 16'(pulses - p0), 16'd1);
        check("post_reset_code", key_code, 4'h8);
        check("post_reset_num", num, 16'h0008);
        hold(16'h0000, 2);

        press(0); press(1); press(2); press(4); settle();
        check("pre_clear_num", num, 16'h1234);
        next_scan();
        keys = 16'h4000;
        next_scan();
        wait_phase(15);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("clr_acc_valid", key_valid, 1'b1);
        check("clr_acc_code", key_code, 4'hF);
        check("clr_acc_num", num, 16'h0000);
        hold(16'h0000, 2);

        press(5); settle();
        check("pre_clr_num", num, 16'h0005);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("clr_alone_num", num, 16'h0000);
        repeat (4) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
